// File: rtl/jtag_master.sv
// JTAG master: drives TCK/TMS/TDI to walk a TAP through reset, IR/DR scans and back to Run-Test/Idle.
// Optional macro JTAG_MASTER_TRST_EN adds a driven TRST_OUT pulse during the INIT sequence.
module jtag_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_IR,
  input  logic [4:0]  CMD_LEN,
  input  logic [31:0] CMD_DATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_DATA,
  output logic        TCK,
  output logic        TMS,
  output logic        TDI,
  input  logic        TDO,
  output logic        TRST_OUT
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    HEAD  = 3'd2,
    SHIFT = 3'd3,
    TAIL  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_div;
  logic [5:0]  r_cnt;
  logic        r_ir;
  logic [4:0]  r_len;
  logic [31:0] r_sh;
  logic [31:0] r_cap;
  logic        r_tck;
  logic        r_tms;
  logic        r_tdi;
  logic        r_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        w_active;
  logic        w_tick;
  logic        w_rise;
  logic        w_fall;
  logic        w_last;

  // TCK edge decode and "last period of this state" flag
  always_comb begin
    w_active = (r_state == INIT) || (r_state == HEAD) || (r_state == SHIFT) || (r_state == TAIL);
    w_tick   = w_active && (r_div == DIV_M1);
    w_rise   = w_tick && !r_tck;
    w_fall   = w_tick && r_tck;
    case (r_state)
      INIT:    w_last = (r_cnt == 6'd5);
      HEAD:    w_last = (r_cnt == (r_ir ? 6'd3 : 6'd2));
      SHIFT:   w_last = (r_cnt == {1'b0, r_len});
      TAIL:    w_last = (r_cnt == 6'd1);
      default: w_last = 1'b0;
    endcase
  end

  // Next-state logic; every phase ends on the falling TCK edge of its last period
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:  if (w_fall && w_last) w_state_nxt = IDLE;  else w_state_nxt = INIT;
      IDLE:  if (CMD_VALID)        w_state_nxt = HEAD;  else w_state_nxt = IDLE;
      HEAD:  if (w_fall && w_last) w_state_nxt = SHIFT; else w_state_nxt = HEAD;
      SHIFT: if (w_fall && w_last) w_state_nxt = TAIL;  else w_state_nxt = SHIFT;
      TAIL:  if (w_fall && w_last) w_state_nxt = DONE;  else w_state_nxt = TAIL;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= INIT;
    else      r_state <= w_state_nxt;
  end

  // TCK half-period divider and TCK itself; TCK parks low whenever no period is pending
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_div <= 8'd0;
      r_tck <= 1'b0;
    end else begin
      if (!w_active || w_tick) r_div <= 8'd0;
      else                     r_div <= r_div + 8'd1;
      if (w_tick)              r_tck <= ~r_tck;
      else if (!w_active)      r_tck <= 1'b0;
      else                     r_tck <= r_tck;
    end
  end

  // Scan datapath: TMS/TDI set up for the next period on each falling edge, TDO captured on rising edges.
  // Leaving INIT or TAIL pre-loads TMS=1, the first HEAD bit, so TMS never moves outside a falling edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= 6'd0;
      r_tms <= 1'b1;
      r_tdi <= 1'b0;
      r_ir  <= 1'b0;
      r_len <= 5'd0;
      r_sh  <= 32'd0;
      r_cap <= 32'd0;
    end else begin
      if (r_state == IDLE && CMD_VALID) begin
        r_ir  <= CMD_IR;
        r_len <= CMD_LEN;
        r_sh  <= CMD_DATA;
        r_cap <= 32'd0;
        r_cnt <= 6'd0;
      end
      if (w_rise && r_state == SHIFT) r_cap[r_cnt[4:0]] <= TDO;
      if (w_fall) begin
        r_cnt <= w_last ? 6'd0 : r_cnt + 6'd1;
        case (r_state)
          INIT: begin
            r_tms <= w_last || (r_cnt < 6'd4);
            r_tdi <= 1'b0;
          end
          HEAD: begin
            r_tms <= w_last ? (r_len == 5'd0) : (r_ir && r_cnt == 6'd0);
            r_tdi <= w_last ? r_sh[0] : 1'b0;
          end
          SHIFT: begin
            r_tms <= w_last || (r_cnt + 6'd1 == {1'b0, r_len});
            r_tdi <= w_last ? 1'b0 : r_sh[1];
            r_sh  <= r_sh >> 1;
          end
          TAIL: begin
            r_tms <= w_last;
            r_tdi <= 1'b0;
          end
          default: begin
            r_tms <= r_tms;
            r_tdi <= r_tdi;
          end
        endcase
      end
    end
  end

  // Handshake outputs, registered to line up with the state they belong to
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
    end else begin
      r_ready     <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == DONE);
      if (w_state_nxt == DONE) r_rsp_data <= r_cap;
    end
  end

`ifdef JTAG_MASTER_TRST_EN
  logic r_trst;

  // TRST held low through reset and the five TMS=1 periods of INIT
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_trst <= 1'b0;
    else if (r_state == INIT && w_fall && r_cnt == 6'd4) r_trst <= 1'b1;
    else r_trst <= r_trst;
  end

  assign TRST_OUT = r_trst;
`else
  assign TRST_OUT = 1'b1;
`endif

  assign CMD_READY = r_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
  assign TCK       = r_tck;
  assign TMS       = r_tms;
  assign TDI       = r_tdi;

endmodule

// File: tb/tb_jtag_master.sv
// Scoreboard bench for jtag_master: a behavioural TAP state model watches TCK/TMS/TDI and
// expected responses are queued at command acceptance and checked when RSP_VALID appears.
module tb_jtag_master;
  localparam int DIV = 2;
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PAUDR = 6, EX2DR = 7;
  localparam int UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_IR = 1'b0;
  logic [4:0]  CMD_LEN = 5'd0;
  logic [31:0] CMD_DATA = 32'd0;
  logic        CMD_READY, RSP_VALID, TCK, TMS, TDI, TDO, TRST_OUT;
  logic [31:0] RSP_DATA;

  int checks = 0;
  int errors = 0;

  // stimulus-side settings for the target model
  bit          tdo_mode = 1'b0;   // 0: TDO looped from TDI, 1: TDO from pat
  logic [31:0] pat = 32'd0;

  // monitor-side observation state
  int          k = 0;
  int          tap = SHDR;
  logic [63:0] tms_v = 64'd0;
  int          tms_n = 0;
  logic [63:0] tdi_v = 64'd0;
  int          rises = 0, first_st = 0, last_st = 0, trst_low = 0;
  int          updr_n = 0, upir_n = 0, edge_viol = 0, cyc = 0;
  int          acc_cnt = 0, rsp_cnt = 0;
  bit          init_pend = 1'b1;
  logic        prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;

  typedef struct {
    bit          ir;
    int          len;
    logic [31:0] data;
    logic [31:0] rsp;
  } exp_t;
  exp_t sb_q[$];

  jtag_master #(.CLK_DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_IR(CMD_IR),
    .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TRST_OUT(TRST_OUT)
  );

  always #5 CLK = ~CLK;

  assign TDO = tdo_mode ? ((k < 32) ? pat[k[4:0]] : 1'b0) : TDI;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int tap_next(input int s, input logic t);
    case (s)
      TLR:   return t ? TLR   : RTI;
      RTI:   return t ? SELDR : RTI;
      SELDR: return t ? SELIR : CAPDR;
      CAPDR: return t ? EX1DR : SHDR;
      SHDR:  return t ? EX1DR : SHDR;
      EX1DR: return t ? UPDR  : PAUDR;
      PAUDR: return t ? EX2DR : PAUDR;
      EX2DR: return t ? UPDR  : SHDR;
      UPDR:  return t ? SELDR : RTI;
      SELIR: return t ? TLR   : CAPIR;
      CAPIR: return t ? EX1IR : SHIR;
      SHIR:  return t ? EX1IR : SHIR;
      EX1IR: return t ? UPIR  : PAUIR;
      PAUIR: return t ? EX2IR : PAUIR;
      EX2IR: return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int len);
    logic [63:0] m;
    m = (64'd1 << (len + 1)) - 64'd1;
    return m[31:0];
  endfunction

  // TMS walk: Select(-IR), Capture, Shift... last shift bit exits, Update, back to Run-Test/Idle
  function automatic logic [63:0] tms_seq(input bit ir, input int len);
    logic [63:0] v;
    int p;
    v = 64'd0;
    p = 0;
    v[p] = 1'b1; p++;
    if (ir) begin v[p] = 1'b1; p++; end
    p = p + 2 + len;
    v[p] = 1'b1; p++;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic clear_logs();
    tms_v = 64'd0; tms_n = 0; tdi_v = 64'd0; rises = 0; k = 0;
    updr_n = 0; upir_n = 0;
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST) begin
        clear_logs();
        trst_low = 0;
        sb_q.delete();
        init_pend = 1'b1;
      end else begin
        if (TCK && !prev_tck) begin
          if (rises == 0) first_st = cyc;
          last_st = cyc;
          rises++;
          if (tms_n < 64) tms_v[tms_n] = TMS;
          tms_n++;
          if (!TRST_OUT) trst_low++;
          if (tap == SHDR || tap == SHIR) begin
            if (k < 32) tdi_v[k] = TDI;
            k++;
          end
          tap = tap_next(tap, TMS);
          if (tap == UPDR) updr_n++;
          if (tap == UPIR) upir_n++;
        end
        if ((TMS !== prev_tms || TDI !== prev_tdi) && !(prev_tck && !TCK)) edge_viol++;
        if (RSP_VALID) begin
          rsp_cnt++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=%0h expected=none", RSP_DATA);
          end else begin
            e = sb_q.pop_front();
            check("rsp_data", 64'(RSP_DATA), 64'(e.rsp));
            check("tck_periods", 64'(rises), 64'(e.len + (e.ir ? 7 : 6)));
            check("tms_seq", tms_v, tms_seq(e.ir, e.len));
            check("tdi_bits", tdi_v, 64'(e.data & mask_of(e.len)));
            check("shift_count", 64'(k), 64'(e.len + 1));
            check("tap_end_state", 64'(tap), 64'(RTI));
            check("update_pulses", 64'(upir_n * 16 + updr_n), e.ir ? 64'd16 : 64'd1);
            check("tck_timing", 64'(last_st - first_st), 64'((rises - 1) * 2 * DIV));
          end
        end
        if (init_pend && CMD_READY) begin
          init_pend = 1'b0;
          check("init_periods", 64'(rises), 64'd6);
          check("init_tms", tms_v, 64'h1F);
          check("init_timing", 64'(last_st - first_st), 64'(5 * 2 * DIV));
          check("init_tap", 64'(tap), 64'(RTI));
`ifdef JTAG_MASTER_TRST_EN
          check("init_trst_low", 64'(trst_low), 64'd5);
`else
          check("init_trst_low", 64'(trst_low), 64'd0);
`endif
        end
        if (CMD_VALID && CMD_READY) begin
          check("accept_one_outstanding", 64'(sb_q.size()), 64'd0);
          check("tck_idle_low", 64'(TCK), 64'd0);
          acc_cnt++;
          e.ir   = CMD_IR;
          e.len  = int'(CMD_LEN);
          e.data = CMD_DATA;
          e.rsp  = (tdo_mode ? pat : CMD_DATA) & mask_of(int'(CMD_LEN));
          sb_q.push_back(e);
          clear_logs();
        end
      end
      prev_tck = TCK; prev_tms = TMS; prev_tdi = TDI;
    end
  end

  task automatic check_reset_outputs();
    @(negedge CLK);
    check("rst_tck", 64'(TCK), 64'd0);
    check("rst_tms", 64'(TMS), 64'd1);
    check("rst_tdi", 64'(TDI), 64'd0);
    check("rst_ready", 64'(CMD_READY), 64'd0);
    check("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    check("rst_rsp_data", 64'(RSP_DATA), 64'd0);
`ifdef JTAG_MASTER_TRST_EN
    check("rst_trst", 64'(TRST_OUT), 64'd0);
`else
    check("rst_trst", 64'(TRST_OUT), 64'd1);
`endif
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!CMD_READY && w < 500) begin
      @(posedge CLK); #2;
      w++;
    end
    check("ready_timeout", 64'(CMD_READY), 64'd1);
  endtask

  task automatic issue(input bit ir, input int len, input logic [31:0] data, input bit mode, input logic [31:0] p);
    int a0, w;
    @(posedge CLK); #2;
    tdo_mode = mode; pat = p;
    CMD_IR = ir; CMD_LEN = 5'(len); CMD_DATA = data; CMD_VALID = 1'b1;
    a0 = acc_cnt; w = 0;
    while (acc_cnt == a0 && w < 200) begin
      @(posedge CLK); #2;
      w++;
    end
    CMD_VALID = 1'b0;
    check("accept_timeout", 64'(acc_cnt - a0), 64'd1);
  endtask

  task automatic scan(input bit ir, input int len, input logic [31:0] data, input bit mode, input logic [31:0] p);
    int r0, w;
    r0 = rsp_cnt;
    issue(ir, len, data, mode, p);
    w = 0;
    while (rsp_cnt == r0 && w < 2000) begin
      @(posedge CLK); #2;
      w++;
    end
    check("rsp_timeout", 64'(rsp_cnt - r0), 64'd1);
  endtask

  initial begin
    int a0, r0, w;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    check_reset_outputs();
    @(posedge CLK); #2;
    RST = 1'b1;
    wait_ready();

    scan(1'b0, 7, 32'h0000_00A5, 1'b0, 32'd0);
    scan(1'b1, 3, 32'h0000_0009, 1'b0, 32'd0);
    scan(1'b0, 31, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    scan(1'b0, 0, 32'h0000_0001, 1'b0, 32'd0);
    scan(1'b1, 31, $urandom, 1'b1, $urandom);
    for (int i = 0; i < 14; i++) begin
      scan(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom, 1'($urandom_range(0, 1)), $urandom);
    end

    // CMD_VALID held across two scans
    @(posedge CLK); #2;
    tdo_mode = 1'b0;
    CMD_IR = 1'b0; CMD_LEN = 5'd5; CMD_DATA = $urandom; CMD_VALID = 1'b1;
    a0 = acc_cnt; r0 = rsp_cnt; w = 0;
    while (rsp_cnt < r0 + 2 && w < 2000) begin
      @(posedge CLK); #2;
      w++;
    end
    CMD_VALID = 1'b0;
    check("hold_accepts", 64'(acc_cnt - a0), 64'd2);
    check("hold_rsps", 64'(rsp_cnt - r0), 64'd2);
    repeat (4) @(posedge CLK);
    #2;
    check("hold_ready_after", 64'(CMD_READY), 64'd1);

    // reset while shifting bit 4
    issue(1'b0, 7, $urandom, 1'b0, 32'd0);
    w = 0;
    while (k < 4 && w < 500) begin
      @(posedge CLK); #2;
      w++;
    end
    check("reach_shift_bit4", 64'(k), 64'd4);
    repeat (DIV + 1) @(posedge CLK);
    #2;
    r0 = rsp_cnt;
    RST = 1'b0;
    check_reset_outputs();
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    wait_ready();
    check("no_rsp_after_reset", 64'(rsp_cnt - r0), 64'd0);
    scan(1'b1, 4, $urandom, 1'b1, $urandom);

    check("edge_discipline", 64'(edge_viol), 64'd0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
